// File: rtl/inst_decode.sv
// IF/ID pipeline register, instruction decode and ID-stage control-transfer resolution for the MIPS-subset core.
// Redirects fetch combinationally, squashes the single wrong-path word, and registers the ID/EX control bundle.
module inst_decode #(
   parameter int LINK_REG = 31,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      Inst_code,
   input  logic [31:0]      PC_new,
   input  logic [31:0]      R_Data_A,
   input  logic [31:0]      R_Data_B,
   output logic [4:0]       R_Addr_A,
   output logic [4:0]       R_Addr_B,
   output logic [1:0]       PC_s,
   output logic [15:0]      imm_data,
   output logic [25:0]      address,
   output logic             ex_valid,
   output logic [3:0]       ex_alu_op,
   output logic             ex_alu_src_imm,
   output logic [31:0]      ex_imm32,
   output logic [31:0]      ex_rs_val,
   output logic [31:0]      ex_rt_val,
   output logic [4:0]       ex_shamt,
   output logic [4:0]       ex_w_addr,
   output logic             ex_reg_write,
   output logic             ex_mem_write,
   output logic             ex_mem_to_reg,
   output logic             ex_link,
   output logic [31:0]      ex_link_pc,
   output logic             ill_inst,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_SLL   = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08, FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22, FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27, FN_SLT  = 6'h2A;
   localparam logic [3:0] ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8, ALU_LUI = 4'd9;
   localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   state_t           state_q;
   logic [31:0]      id_inst_q, id_pc_q;
   logic             id_valid_q;
   logic [CNT_W-1:0] flush_cnt_q, retired_cnt_q;

   logic             ex_valid_q, ex_alu_src_imm_q, ex_reg_write_q, ex_mem_write_q;
   logic             ex_mem_to_reg_q, ex_link_q, ill_inst_q;
   logic [3:0]       ex_alu_op_q;
   logic [31:0]      ex_imm32_q, ex_rs_val_q, ex_rt_val_q, ex_link_pc_q;
   logic [4:0]       ex_shamt_q, ex_w_addr_q;

   logic [5:0]       opcode_s, funct_s;
   logic [3:0]       alu_op_d;
   logic             alu_src_imm_d, zext_s, rd_dest_s, wr_en_s, mem_write_s, mem_to_reg_s;
   logic             link_s, known_s, is_beq_s, is_bne_s, is_jump_s, is_jr_s;
   logic [4:0]       w_addr_d;
   logic [31:0]      imm32_d;
   logic             live_s, ill_s, eq_s, br_taken_s, take_s;

   assign opcode_s = id_inst_q[31:26];
   assign funct_s  = id_inst_q[5:0];
   assign R_Addr_A = id_inst_q[25:21];
   assign R_Addr_B = id_inst_q[20:16];
   assign address  = id_inst_q[25:0];
   // Fetch adds to the PC+4 of the word behind the branch, so hand it offset-1.
   assign imm_data = id_inst_q[15:0] - 16'd1;

   always_comb begin
      alu_op_d      = ALU_ADD;
      alu_src_imm_d = 1'b0;
      zext_s        = 1'b0;
      rd_dest_s     = 1'b0;
      wr_en_s       = 1'b0;
      mem_write_s   = 1'b0;
      mem_to_reg_s  = 1'b0;
      link_s        = 1'b0;
      known_s       = 1'b1;
      is_beq_s      = 1'b0;
      is_bne_s      = 1'b0;
      is_jump_s     = 1'b0;
      is_jr_s       = 1'b0;
      case (opcode_s)
         OP_RTYPE: begin
            rd_dest_s = 1'b1;
            wr_en_s   = 1'b1;
            case (funct_s)
               FN_ADD:  alu_op_d = ALU_ADD;
               FN_SUB:  alu_op_d = ALU_SUB;
               FN_AND:  alu_op_d = ALU_AND;
               FN_OR:   alu_op_d = ALU_OR;
               FN_XOR:  alu_op_d = ALU_XOR;
               FN_NOR:  alu_op_d = ALU_NOR;
               FN_SLT:  alu_op_d = ALU_SLT;
               FN_SLL:  alu_op_d = ALU_SLL;
               FN_SRL:  alu_op_d = ALU_SRL;
               FN_JR: begin
                  wr_en_s = 1'b0;
                  is_jr_s = 1'b1;
               end
               default: begin
                  wr_en_s = 1'b0;
                  known_s = 1'b0;
               end
            endcase
         end
         OP_ADDI: begin
            alu_src_imm_d = 1'b1;
            wr_en_s       = 1'b1;
         end
         OP_SLTI: begin
            alu_op_d      = ALU_SLT;
            alu_src_imm_d = 1'b1;
            wr_en_s       = 1'b1;
         end
         OP_ANDI: begin
            alu_op_d      = ALU_AND;
            alu_src_imm_d = 1'b1;
            zext_s        = 1'b1;
            wr_en_s       = 1'b1;
         end
         OP_ORI: begin
            alu_op_d      = ALU_OR;
            alu_src_imm_d = 1'b1;
            zext_s        = 1'b1;
            wr_en_s       = 1'b1;
         end
         OP_XORI: begin
            alu_op_d      = ALU_XOR;
            alu_src_imm_d = 1'b1;
            zext_s        = 1'b1;
            wr_en_s       = 1'b1;
         end
         OP_LUI: begin
            alu_op_d      = ALU_LUI;
            alu_src_imm_d = 1'b1;
            zext_s        = 1'b1;
            wr_en_s       = 1'b1;
         end
         OP_LW: begin
            alu_src_imm_d = 1'b1;
            wr_en_s       = 1'b1;
            mem_to_reg_s  = 1'b1;
         end
         OP_SW: begin
            alu_src_imm_d = 1'b1;
            mem_write_s   = 1'b1;
         end
         OP_BEQ: begin
            alu_op_d = ALU_SUB;
            is_beq_s = 1'b1;
         end
         OP_BNE: begin
            alu_op_d = ALU_SUB;
            is_bne_s = 1'b1;
         end
         OP_J:    is_jump_s = 1'b1;
         OP_JAL: begin
            is_jump_s = 1'b1;
            link_s    = 1'b1;
            wr_en_s   = 1'b1;
         end
         default: known_s = 1'b0;
      endcase
   end

   assign w_addr_d   = link_s ? LINK_ADDR : (rd_dest_s ? id_inst_q[15:11] : id_inst_q[20:16]);
   assign imm32_d    = zext_s ? {16'h0000, id_inst_q[15:0]} : {{16{id_inst_q[15]}}, id_inst_q[15:0]};
   assign live_s     = id_valid_q & known_s;
   assign ill_s      = id_valid_q & ~known_s;
   assign eq_s       = (R_Data_A == R_Data_B);
   assign br_taken_s = live_s & ((is_beq_s & eq_s) | (is_bne_s & ~eq_s));
   assign take_s     = br_taken_s | (live_s & (is_jump_s | is_jr_s));

   // Fetch redirect select; idle whenever ID holds no live word.
   always_comb begin
      if (!live_s) begin
         PC_s = 2'b00;
      end else if (is_jr_s) begin
         PC_s = 2'b01;
      end else if (br_taken_s) begin
         PC_s = 2'b10;
      end else if (is_jump_s) begin
         PC_s = 2'b11;
      end else begin
         PC_s = 2'b00;
      end
   end

   // IF/ID register and squash FSM: the word latched on a take edge is the one wrong-path word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         id_inst_q   <= 32'h0000_0000;
         id_pc_q     <= 32'h0000_0000;
         id_valid_q  <= 1'b0;
         flush_cnt_q <= '0;
      end else begin
         id_inst_q <= Inst_code;
         id_pc_q   <= PC_new;
         case (state_q)
            S_RUN: begin
               if (take_s) begin
                  state_q     <= S_FLUSH;
                  id_valid_q  <= 1'b0;
                  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
               end else begin
                  state_q    <= S_RUN;
                  id_valid_q <= 1'b1;
               end
            end
            S_FLUSH: begin
               state_q    <= S_RUN;
               id_valid_q <= 1'b1;
            end
            default: begin
               state_q    <= S_RUN;
               id_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // ID/EX bundle; side-effect enables are gated so bubbles and illegal words do nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q       <= 1'b0;
         ex_alu_op_q      <= 4'd0;
         ex_alu_src_imm_q <= 1'b0;
         ex_imm32_q       <= 32'h0000_0000;
         ex_rs_val_q      <= 32'h0000_0000;
         ex_rt_val_q      <= 32'h0000_0000;
         ex_shamt_q       <= 5'd0;
         ex_w_addr_q      <= 5'd0;
         ex_reg_write_q   <= 1'b0;
         ex_mem_write_q   <= 1'b0;
         ex_mem_to_reg_q  <= 1'b0;
         ex_link_q        <= 1'b0;
         ex_link_pc_q     <= 32'h0000_0000;
         ill_inst_q       <= 1'b0;
         retired_cnt_q    <= '0;
      end else begin
         ex_valid_q       <= live_s;
         ex_alu_op_q      <= alu_op_d;
         ex_alu_src_imm_q <= alu_src_imm_d;
         ex_imm32_q       <= imm32_d;
         ex_rs_val_q      <= R_Data_A;
         ex_rt_val_q      <= R_Data_B;
         ex_shamt_q       <= id_inst_q[10:6];
         ex_w_addr_q      <= w_addr_d;
         ex_reg_write_q   <= live_s & wr_en_s & (w_addr_d != 5'd0);
         ex_mem_write_q   <= live_s & mem_write_s;
         ex_mem_to_reg_q  <= live_s & mem_to_reg_s;
         ex_link_q        <= live_s & link_s;
         ex_link_pc_q     <= id_pc_q;
         ill_inst_q       <= ill_s;
         retired_cnt_q    <= retired_cnt_q + (live_s ? CNT_W'(1) : CNT_W'(0));
      end
   end

   assign ex_valid       = ex_valid_q;
   assign ex_alu_op      = ex_alu_op_q;
   assign ex_alu_src_imm = ex_alu_src_imm_q;
   assign ex_imm32       = ex_imm32_q;
   assign ex_rs_val      = ex_rs_val_q;
   assign ex_rt_val      = ex_rt_val_q;
   assign ex_shamt       = ex_shamt_q;
   assign ex_w_addr      = ex_w_addr_q;
   assign ex_reg_write   = ex_reg_write_q;
   assign ex_mem_write   = ex_mem_write_q;
   assign ex_mem_to_reg  = ex_mem_to_reg_q;
   assign ex_link        = ex_link_q;
   assign ex_link_pc     = ex_link_pc_q;
   assign ill_inst       = ill_inst_q;
   assign retired_cnt    = retired_cnt_q;
   assign flush_cnt      = flush_cnt_q;
endmodule
